// File: rtl/hue_frame_controller_if.sv
// Pixel stream bundle between the camera side and the hue pipeline side.
//   in_valid/in_sof/in_red/in_green/in_blue : camera pixel stream into the controller
//   out_valid/out_visual/out_done/out_red/out_green/out_blue : stream toward the pipeline
// slave  : controller view (consumes in_*, produces out_*)
// master : camera/pipeline view (produces in_*, consumes out_*)
interface hue_frame_controller_if;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_red;
  logic [7:0] in_green;
  logic [7:0] in_blue;
  logic       out_valid;
  logic       out_visual;
  logic       out_done;
  logic [7:0] out_red;
  logic [7:0] out_green;
  logic [7:0] out_blue;

  modport slave (
    input  in_valid, in_sof, in_red, in_green, in_blue,
    output out_valid, out_visual, out_done, out_red, out_green, out_blue
  );

  modport master (
    output in_valid, in_sof, in_red, in_green, in_blue,
    input  out_valid, out_visual, out_done, out_red, out_green, out_blue
  );
endinterface

// File: rtl/hue_frame_controller.sv
// Frame capture controller in front of a hue pipeline. Arms on start, locks onto
// the next start-of-frame, forwards exactly one frame of pixels with one cycle of
// latency, marks the last pixel (or an abort) with out_done, then waits for the
// pipeline to drain before pulsing frame_done.
// Ports:
//   clock, reset_n   : system clock, synchronous active-low reset
//   i_start, i_stop  : single-cycle arm / abort commands (stop wins)
//   i_continuous     : re-arm after every completed drain
//   pix              : pixel stream interface (slave modport)
//   o_busy           : controller not idle
//   o_frame_done     : one-cycle pulse after drain
//   o_frame_count    : completed frames, wraps at 16 bits
//   o_error          : sticky unexpected-sof flag, cleared by start
module hue_frame_controller #(
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480,
  parameter int unsigned PIPE_LATENCY = 6
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_continuous,
  hue_frame_controller_if.slave        pix,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic [15:0]                  o_frame_count,
  output logic                         o_error
);

  localparam logic [10:0] XLast     = 11'(IMAGE_WIDTH - 1);
  localparam logic [9:0]  YLast     = 10'(IMAGE_HEIGHT - 1);
  localparam logic [3:0]  DrainLoad = 4'(PIPE_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_e;

  state_e      r_state;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [3:0]  r_drain_cnt;
  logic        r_complete;  // drain follows a full frame rather than an abort
  logic        r_out_valid;
  logic        r_out_visual;
  logic        r_out_done;
  logic [7:0]  r_out_red;
  logic [7:0]  r_out_green;
  logic [7:0]  r_out_blue;
  logic        r_busy;
  logic        r_frame_done;
  logic [15:0] r_frame_count;
  logic        r_error;

  logic w_sof_px;
  logic w_last_px;

  assign w_sof_px  = pix.in_valid && pix.in_sof;
  assign w_last_px = (r_x == XLast) && (r_y == YLast);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_x           <= '0;
      r_y           <= '0;
      r_drain_cnt   <= '0;
      r_complete    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_visual  <= 1'b0;
      r_out_done    <= 1'b0;
      r_out_red     <= '0;
      r_out_green   <= '0;
      r_out_blue    <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_error       <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_out_visual <= 1'b0;
      r_out_done   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start && !i_stop) begin
            r_state <= StArmed;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        StArmed: begin
          if (i_stop) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (w_sof_px) begin
            // The sof pixel itself is pixel (0,0); next expected position is (1,0).
            r_out_valid  <= 1'b1;
            r_out_visual <= 1'b1;
            r_out_red    <= pix.in_red;
            r_out_green  <= pix.in_green;
            r_out_blue   <= pix.in_blue;
            r_x          <= 11'd1;
            r_y          <= '0;
            r_state      <= StCapture;
          end
        end
        StCapture: begin
          if (i_stop || w_sof_px) begin
            // Abort: the offending pixel is dropped and a bare done marker is sent.
            if (w_sof_px) r_error <= 1'b1;
            r_out_done  <= 1'b1;
            r_complete  <= 1'b0;
            r_drain_cnt <= DrainLoad;
            r_state     <= StDrain;
          end else if (pix.in_valid) begin
            r_out_valid  <= 1'b1;
            r_out_visual <= 1'b1;
            r_out_red    <= pix.in_red;
            r_out_green  <= pix.in_green;
            r_out_blue   <= pix.in_blue;
            if (w_last_px) begin
              r_out_done  <= 1'b1;
              r_complete  <= 1'b1;
              r_drain_cnt <= DrainLoad;
              r_state     <= StDrain;
            end else if (r_x == XLast) begin
              r_x <= '0;
              r_y <= r_y + 10'd1;
            end else begin
              r_x <= r_x + 11'd1;
            end
          end
        end
        StDrain: begin
          if (r_drain_cnt == 4'd0) begin
            r_frame_done <= 1'b1;
            if (r_complete) r_frame_count <= r_frame_count + 16'd1;
            if (i_continuous) begin
              r_state <= StArmed;
              r_x     <= '0;
              r_y     <= '0;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pix.out_valid  = r_out_valid;
  assign pix.out_visual = r_out_visual;
  assign pix.out_done   = r_out_done;
  assign pix.out_red    = r_out_red;
  assign pix.out_green  = r_out_green;
  assign pix.out_blue   = r_out_blue;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;
  assign o_frame_count  = r_frame_count;
  assign o_error        = r_error;

endmodule

// File: tb/tb_hue_frame_controller.sv
// Scoreboard bench for hue_frame_controller with a 4x2 image and 6-cycle drain.
module tb_hue_frame_controller;
  localparam int unsigned W = 4;
  localparam int unsigned H = 2;
  localparam int unsigned L = 6;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        cont    = 1'b0;
  logic        busy;
  logic        fd;
  logic        err;
  logic [15:0] fc;

  hue_frame_controller_if pix_if ();

  hue_frame_controller #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIPE_LATENCY(L)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_continuous (cont),
    .pix          (pix_if),
    .o_busy       (busy),
    .o_frame_done (fd),
    .o_frame_count(fc),
    .o_error      (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        last;
    logic [23:0] rgb;
    logic [31:0] stamp;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_fd     = 0;
  int unsigned n_abort  = 0;
  int unsigned last_done_cyc = 0;
  int unsigned fd_delta = 0;
  int unsigned abort_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every forwarded pixel.
  always @(negedge clock) begin : mon
    exp_t e;
    if (pix_if.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_px", 32'(pix_if.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("px_rgb", {8'd0, pix_if.out_red, pix_if.out_green, pix_if.out_blue},
                 {8'd0, e.rgb});
        check_eq("px_done", 32'(pix_if.out_done), 32'(e.last));
        check_eq("px_visual", 32'(pix_if.out_visual), 32'd1);
        check_eq("px_latency", cyc, e.stamp + 1);
      end
    end else begin
      check_eq("visual_idle", 32'(pix_if.out_visual), 32'd0);
      if (pix_if.out_done === 1'b1) begin
        n_abort++;
        abort_cyc = cyc;
      end
    end
    if (pix_if.out_done === 1'b1) last_done_cyc = cyc;
    if (fd === 1'b1) begin
      n_fd++;
      fd_delta = cyc - last_done_cyc;
    end
  end

  task automatic drive(input logic st, input logic sp, input logic v, input logic sof,
                       input logic fwd, input logic last);
    logic [23:0] rgb;
    rgb = 24'($urandom);
    @(negedge clock);
    start           = st;
    stop            = sp;
    pix_if.in_valid = v;
    pix_if.in_sof   = sof;
    pix_if.in_red   = rgb[23:16];
    pix_if.in_green = rgb[15:8];
    pix_if.in_blue  = rgb[7:0];
    if (fwd) exp_q.push_back('{last: last, rgb: rgb, stamp: cyc});
  endtask

  task automatic px(input logic sof, input logic fwd, input logic last);
    drive(1'b0, 1'b0, 1'b1, sof, fwd, last);
  endtask

  task automatic cmd(input logic st, input logic sp);
    drive(st, sp, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic fwd);
    for (int i = 0; i < int'(W * H); i++) px(i == 0, fwd, fwd && (i == int'(W * H) - 1));
    idle(1);
  endtask

  task automatic wait_fd(input int unsigned prev);
    int unsigned k;
    k = 0;
    while (n_fd == prev && k < 40) begin
      idle(1);
      k++;
    end
    check_eq("frame_done_seen", n_fd, prev + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_fd"}, 32'(fd), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(pix_if.out_valid), 32'd0);
    check_eq({tag, "_out_done"}, 32'(pix_if.out_done), 32'd0);
    check_eq({tag, "_out_visual"}, 32'(pix_if.out_visual), 32'd0);
    check_eq({tag, "_out_rgb"}, {8'd0, pix_if.out_red, pix_if.out_green, pix_if.out_blue},
             32'd0);
    check_eq({tag, "_count"}, 32'(fc), 32'd0);
    check_eq({tag, "_error"}, 32'(err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned prev_fd;
    int unsigned prev_abort;
    int unsigned stop_cyc;

    pix_if.in_valid = 1'b0;
    pix_if.in_sof   = 1'b0;
    pix_if.in_red   = '0;
    pix_if.in_green = '0;
    pix_if.in_blue  = '0;

    // Reset state
    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Normal frame
    prev_fd = n_fd;
    cmd(1'b1, 1'b0);
    idle(1);
    check_eq("armed_busy", 32'(busy), 32'd1);
    send_frame(1'b1);
    wait_fd(prev_fd);
    check_eq("normal_fd_delay", fd_delta, L);
    check_eq("normal_count", 32'(fc), 32'd1);
    idle(1);
    check_eq("normal_busy_after", 32'(busy), 32'd0);
    check_eq("normal_q_empty", exp_q.size(), 32'd0);

    // Continuous mode over two frames, with stray pixels between them
    cont = 1'b1;
    prev_fd = n_fd;
    cmd(1'b1, 1'b0);
    send_frame(1'b1);
    repeat (3) px(1'b0, 1'b0, 1'b0);
    wait_fd(prev_fd);
    check_eq("cont_count1", 32'(fc), 32'd2);
    idle(2);
    check_eq("cont_rearmed_busy", 32'(busy), 32'd1);
    px(1'b0, 1'b0, 1'b0);
    prev_fd = n_fd;
    send_frame(1'b1);
    cont = 1'b0;
    wait_fd(prev_fd);
    check_eq("cont_count2", 32'(fc), 32'd3);
    idle(1);
    check_eq("cont_busy_after", 32'(busy), 32'd0);
    check_eq("cont_q_empty", exp_q.size(), 32'd0);

    // Abort with stop after pixel 3
    prev_fd    = n_fd;
    prev_abort = n_abort;
    cmd(1'b1, 1'b0);
    px(1'b1, 1'b1, 1'b0);
    px(1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b1, 1'b0);
    cmd(1'b0, 1'b1);
    stop_cyc = cyc;
    repeat (5) px(1'b0, 1'b0, 1'b0);
    wait_fd(prev_fd);
    check_eq("abort_marker", n_abort, prev_abort + 1);
    check_eq("abort_marker_cycle", abort_cyc, stop_cyc + 1);
    check_eq("abort_fd_delay", fd_delta, L);
    check_eq("abort_count", 32'(fc), 32'd3);
    idle(1);
    check_eq("abort_busy_after", 32'(busy), 32'd0);
    check_eq("abort_q_empty", exp_q.size(), 32'd0);

    // Early sof at pixel 5
    prev_fd    = n_fd;
    prev_abort = n_abort;
    cmd(1'b1, 1'b0);
    px(1'b1, 1'b1, 1'b0);
    repeat (3) px(1'b0, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b0);
    wait_fd(prev_fd);
    check_eq("sof_error", 32'(err), 32'd1);
    check_eq("sof_abort_marker", n_abort, prev_abort + 1);
    check_eq("sof_count", 32'(fc), 32'd3);
    check_eq("sof_q_empty", exp_q.size(), 32'd0);
    cmd(1'b1, 1'b0);
    idle(1);
    check_eq("sof_error_cleared", 32'(err), 32'd0);
    check_eq("sof_rearm_busy", 32'(busy), 32'd1);
    cmd(1'b0, 1'b1);
    idle(1);
    check_eq("armed_stop_busy", 32'(busy), 32'd0);

    // Reset mid-capture after pixel 2
    prev_fd    = n_fd;
    prev_abort = n_abort;
    cmd(1'b1, 1'b0);
    px(1'b1, 1'b1, 1'b0);
    px(1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    idle(1);
    check_all_zero("midreset");
    reset_n = 1'b1;
    send_frame(1'b0);
    idle(10);
    check_eq("midreset_busy", 32'(busy), 32'd0);
    check_eq("midreset_no_fd", n_fd, prev_fd);
    check_eq("midreset_no_done", n_abort, prev_abort);
    check_eq("midreset_q_empty", exp_q.size(), 32'd0);

    // start+stop together in IDLE, then start while ARMED
    cmd(1'b1, 1'b1);
    idle(1);
    check_eq("startstop_idle_busy", 32'(busy), 32'd0);
    cmd(1'b1, 1'b0);
    idle(1);
    check_eq("start_busy", 32'(busy), 32'd1);
    cmd(1'b1, 1'b0);
    idle(1);
    check_eq("start_in_armed_busy", 32'(busy), 32'd1);
    prev_fd = n_fd;
    send_frame(1'b1);
    wait_fd(prev_fd);
    check_eq("post_reset_count", 32'(fc), 32'd1);
    idle(1);
    check_eq("final_busy", 32'(busy), 32'd0);
    check_eq("final_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hue_frame_controller.md
HUE_FRAME_CONTROLLER -- requirements
Module: hue_frame_controller

Interface
REQ-001 Parameter IMAGE_WIDTH, default 640, pixels per line; legal range 2..2047.
REQ-002 Parameter IMAGE_HEIGHT, default 480, lines per frame; legal range 1..1023.
REQ-003 Parameter PIPE_LATENCY, default 6, downstream hue pipeline depth in cycles; legal range 1..15.
REQ-004 clock  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  single-cycle command: arm capture.
REQ-007 stop  in  1  single-cycle command: abort or disarm.
REQ-008 continuous  in  1  level; re-arm automatically after each completed frame.
REQ-009 in_valid  in  1  camera pixel strobe.
REQ-010 in_sof  in  1  start-of-frame, qualified by in_valid, coincident with pixel (0,0).
REQ-011 in_red/in_green/in_blue  in  8 each  camera pixel components.
REQ-012 out_valid  out  1  pixel strobe toward the hue pipeline.
REQ-013 out_red/out_green/out_blue  out  8 each  forwarded components.
REQ-014 out_visual  out  1  pixel belongs to the active frame.
REQ-015 out_done  out  1  last-pixel or abort marker toward the pipeline.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 frame_done  out  1  one-cycle pulse when the pipeline has drained a frame.
REQ-018 frame_count  out  16  number of completed frames; wraps from 0xFFFF to 0.
REQ-019 error  out  1  sticky error flag for an unexpected in_sof.

Function
REQ-020 The controller SHALL use the states IDLE, ARMED, CAPTURE, DRAIN.
REQ-021 In IDLE, start SHALL cause a transition to ARMED and SHALL clear error.
REQ-022 In ARMED, in_valid&in_sof SHALL cause a transition to CAPTURE, and that pixel SHALL be forwarded as pixel (0,0).
REQ-023 In CAPTURE, each in_valid pixel SHALL be forwarded, and x (11b) and y (10b) counters SHALL advance; x SHALL wrap at IMAGE_WIDTH-1 and increment y.
REQ-024 The forwarding of pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) SHALL assert out_done with out_valid, and the controller SHALL enter DRAIN.
REQ-025 All outputs SHALL be registered, with exactly 1 cycle of latency from the input pixel to out_valid/out_*.
REQ-026 For each forwarded pixel, out_visual SHALL equal 1; when out_valid=0, out_visual SHALL be 0 and out_red/green/blue SHALL hold their last value.
REQ-027 Pixels outside CAPTURE (and not the entry pixel of REQ-022) SHALL be dropped, with out_valid=0.
REQ-028 DRAIN SHALL last PIPE_LATENCY cycles; on its last cycle, frame_done SHALL pulse for 1 cycle.
REQ-029 On a completed frame, frame_count SHALL increment together with frame_done.
REQ-030 After DRAIN, the next state SHALL be ARMED if continuous=1 on that cycle, else IDLE.
REQ-031 stop in ARMED SHALL cause a transition to IDLE.
REQ-032 stop in CAPTURE SHALL abort: out_done=1 with out_valid=0 for 1 cycle, then DRAIN; frame_done SHALL still pulse, and frame_count SHALL NOT increment.
REQ-033 in_sof during CAPTURE at a position other than (0,0) SHALL set error, SHALL drop that pixel and SHALL be handled as an abort per REQ-032.
REQ-034 start and stop in the same cycle: stop SHALL win.
REQ-035 start in ARMED, CAPTURE or DRAIN SHALL be ignored; stop in IDLE or DRAIN SHALL be ignored.
REQ-036 Counters x and y SHALL reset to 0 on entry to ARMED.

Reset
REQ-037 reset_n=0 at a clock edge SHALL force IDLE and SHALL clear x, y, frame_count and error.
REQ-038 reset_n=0 at a clock edge SHALL drive out_valid, out_visual, out_done, busy and frame_done to 0, and out_red/green/blue to 0.
REQ-039 Reset mid-CAPTURE or mid-DRAIN SHALL discard the frame, with no frame_done and no out_done.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=2, PIPE_LATENCY=6)
REQ-040 Normal frame: start, then 8 valid pixels with sof on the first -> 8 out_valid pulses each 1 cycle late; out_done on the 8th; frame_done 6 cycles later; frame_count=1; busy low afterwards.
REQ-041 Continuous mode: continuous=1 over two frames -> controller returns to ARMED after the first DRAIN; frame_count=2; pixels between frames dropped.
REQ-042 Abort: stop after pixel 3 -> out_done with out_valid=0 in the next cycle, frame_done after drain, frame_count unchanged, remaining pixels dropped.
REQ-043 Early sof at pixel 5 -> error=1, abort sequence, error cleared by the next start.
REQ-044 Reset mid-CAPTURE after pixel 2 -> all outputs 0 next cycle; state IDLE; subsequent pixels ignored until start.
REQ-045 start+stop in the same cycle while IDLE -> remains IDLE, busy=0; start alone in ARMED -> no state change.
